// File: rtl/regfile_scoreboard_if.sv
// rtl/regfile_scoreboard_if.sv - issue/writeback/read bundle between pipeline and register scoreboard
//
// Purpose: groups the read ports, issue reservation handshake, writeback bus,
// flush and status outputs of regfile_scoreboard.
// Modports:
//   master - pipeline side: drives rd_addr, issue_*, wb_*, flush;
//            observes rd_data, rd_busy, issue_ready, busy_cnt, err.
//   slave  - register file side (the reverse directions).
interface regfile_scoreboard_if #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int NRD    = 2
);
  localparam int ADDR_W = $clog2(NREG);
  localparam int CNT_W  = $clog2(NREG + 1);

  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_busy;
  logic                  issue_valid;
  logic [ADDR_W-1:0]     issue_rd;
  logic                  issue_ready;
  logic                  wb_valid;
  logic [ADDR_W-1:0]     wb_rd;
  logic [DATA_W-1:0]     wb_data;
  logic                  flush;
  logic [CNT_W-1:0]      busy_cnt;
  logic                  err;

  modport master (
    output rd_addr, issue_valid, issue_rd, wb_valid, wb_rd, wb_data, flush,
    input  rd_data, rd_busy, issue_ready, busy_cnt, err
  );

  modport slave (
    input  rd_addr, issue_valid, issue_rd, wb_valid, wb_rd, wb_data, flush,
    output rd_data, rd_busy, issue_ready, busy_cnt, err
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - parametrised register file with busy scoreboard, bypass, flush and error flag
//
// Purpose: integer register file with per-register busy bits for pipelined
// issue/writeback. Register 0 is hardwired to zero and never busy.
// Optional feature macro: REGFILE_BYPASS_EN - when defined, a writeback in
// the current cycle is forwarded combinationally to matching read ports.
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-high reset, clears all state
//   bus - regfile_scoreboard_if.slave: read ports (rd_addr/rd_data/rd_busy),
//         issue reservation (issue_valid/issue_rd/issue_ready), writeback
//         (wb_valid/wb_rd/wb_data), flush, busy_cnt, sticky err.
module regfile_scoreboard #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int NRD    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_scoreboard_if.slave  bus
);
  localparam int ADDR_W = $clog2(NREG);
  localparam int CNT_W  = $clog2(NREG + 1);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [NREG-1:0]   busy_q, busy_d;
  logic [CNT_W-1:0]  busy_cnt_q, busy_cnt_d;
  logic              err_q, err_d;

  logic              issue_ready;
  logic              issue_acc;
  logic              wb_act;

  // Reservation is allowed when the destination is free or is being retired
  // this very cycle (WAW back-to-back without a bubble).
  always_comb begin
    issue_ready = !rst && !bus.flush &&
                  ((bus.issue_rd == '0) || !busy_q[bus.issue_rd] ||
                   (bus.wb_valid && (bus.wb_rd == bus.issue_rd)));
    issue_acc   = bus.issue_valid && issue_ready && (bus.issue_rd != '0);
    wb_act      = bus.wb_valid && (bus.wb_rd != '0);
  end

  // Next busy vector: writeback clears, a reservation to the same index in
  // the same cycle is applied afterwards so it wins. Flush overrides both.
  always_comb begin
    busy_d = busy_q;
    if (bus.flush) begin
      busy_d = '0;
    end else begin
      if (wb_act)    busy_d[bus.wb_rd]    = 1'b0;
      if (issue_acc) busy_d[bus.issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;

    busy_cnt_d = '0;
    for (int i = 0; i < NREG; i++) begin
      busy_cnt_d = busy_cnt_d + CNT_W'(busy_d[i]);
    end

    // A writeback with no matching reservation is a protocol error, unless
    // a flush is cancelling reservations in the same cycle.
    err_d = err_q | (wb_act && !bus.flush && !busy_q[bus.wb_rd]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      busy_q     <= '0;
      busy_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (wb_act) regs_q[bus.wb_rd] <= bus.wb_data;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
      err_q      <= err_d;
    end
  end

  logic [ADDR_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_v;
  logic              rd_b;

  always_comb begin
    bus.rd_data = '0;
    bus.rd_busy = '0;
    rd_a        = '0;
    rd_v        = '0;
    rd_b        = 1'b0;
    for (int k = 0; k < NRD; k++) begin
      rd_a = bus.rd_addr[k*ADDR_W +: ADDR_W];
      rd_v = regs_q[rd_a];
      rd_b = busy_q[rd_a];
`ifdef REGFILE_BYPASS_EN
      if (bus.wb_valid && (bus.wb_rd == rd_a) && (rd_a != '0)) begin
        rd_v = bus.wb_data;
        rd_b = 1'b0;
      end
`endif
      // Array is cleared asynchronously, but gate explicitly so reads are
      // zero for the whole reset window, including any bypass path.
      if (rst) begin
        rd_v = '0;
        rd_b = 1'b0;
      end
      bus.rd_data[k*DATA_W +: DATA_W] = rd_v;
      bus.rd_busy[k]                  = rd_b;
    end
  end

  assign bus.issue_ready = issue_ready;
  assign bus.busy_cnt    = busy_cnt_q;
  assign bus.err         = err_q;
endmodule
